// File: rtl/rf_pkg.sv
// Shared register-file write-port definitions: geometry constants, sequencer states
// and the round-robin pointer increment helper.
package rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_REG_COUNT  = 2 ** RF_ADDR_WIDTH;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } wbseq_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_grant_arbiter.sv
// Writeback grant arbiter: one-hot grant plus index, combinational (zero latency), no backpressure of its own.
// WB_ARB_RR_EN builds round-robin with a rotating priority pointer; otherwise the lowest index wins.
module wb_grant_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
`ifdef WB_ARB_RR_EN
  input  logic               clock,
  input  logic               reset_n,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (gnt == '0 && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // Pointer moves only on an actual grant; a masked request vector leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt != '0) begin
      ptr_d = IDX_W'(rr_next(int'(gnt_idx), NUM_REQ));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_write_sequencer.sv
// Register-file write-port owner: zero-fills every register after reset or init_start, then grants one writeback per cycle.
// Outputs registered (1-cycle latency), req_ready combinational and low during fill/init_start; WB_ARB_RR_EN selects round-robin.
module regfile_write_sequencer
  import rf_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          init_start,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_write_enable,
  output logic [ADDR_WIDTH-1:0]         rf_write_address,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  output logic                          init_done,
  output logic [15:0]                   drop_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  wbseq_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  init_done_q, init_done_d;
  logic [15:0]           drop_q, drop_d;

  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ADDR_WIDTH-1:0] fill_addr;

  // Arbitration opens only once init_done is visible, and never while a restart is requested.
  assign arb_req = req_valid & {NUM_REQ{init_done_q & ~init_start}};

  wb_grant_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
`ifdef WB_ARB_RR_EN
    .clock   (clock),
    .reset_n (reset_n),
`endif
    .req     (arb_req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_addr = req_addr[int'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = req_data[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    drop_d      = drop_q;
    fill_addr   = init_start ? '0 : cnt_q;
    if (init_start || state_q == INIT) begin
      // A restart emits the address-0 step on the very edge that samples it.
      we_d        = 1'b1;
      addr_d      = fill_addr;
      data_d      = '0;
      cnt_d       = fill_addr + 1'b1;
      state_d     = (fill_addr == '1) ? RUN : INIT;
      init_done_d = 1'b0;
    end else begin
      init_done_d = 1'b1;
      if (gnt != '0) begin
        if (sel_addr == '0) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end else begin
          we_d   = 1'b1;
          addr_d = sel_addr;
          data_d = sel_data;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      drop_q      <= drop_d;
    end
  end

  assign req_ready        = gnt;
  assign rf_write_enable  = we_q;
  assign rf_write_address = addr_q;
  assign rf_write_data    = data_q;
  assign init_done        = init_done_q;
  assign drop_count       = drop_q;

endmodule
